dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the single-ported data memory.
- Port 0 is the pipeline MEM stage; port 1 is the debug/loader port.
- Grants one word access at a time, round-robin, and holds memory controls stable for MEM_LAT cycles.
- Returns read data with a one-cycle ack pulse to the owning port.

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-ported data memory.
// Optional `DMEM_ALIGN_CHECK_EN adds err_o and answers unaligned accesses with an error ack instead of touching memory.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [DATA_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [DATA_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              last_grant_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] addr_d, wdata_d;
  logic              rd_d, wr_d;
  logic              ack0_d, ack1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic              err_d;
  logic              grant_p1;

  // Next state, latched request and next registered output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    addr_d       = mem_addr_o;
    wdata_d      = mem_wdata_o;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = p0_rdata_o;
    rdata1_d     = p1_rdata_o;
    err_d        = 1'b0;
    grant_p1     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          // On a tie the port that did not win last time goes first.
          grant_p1     = p1_req_i && (!p0_req_i || !last_grant_q);
          owner_d      = grant_p1;
          we_d         = grant_p1 ? p1_we_i    : p0_we_i;
          addr_d       = grant_p1 ? p1_addr_i  : p0_addr_i;
          wdata_d      = grant_p1 ? p1_wdata_i : p0_wdata_i;
          last_grant_d = grant_p1;
          cnt_d        = CNT_W'(MEM_LAT - 1);
          state_d      = S_ACCESS;
          rd_d         = !we_d;
          wr_d         = we_d;
`ifdef DMEM_ALIGN_CHECK_EN
          if (addr_d[1:0] != 2'b00) begin
            state_d = S_RESP;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = 1'b1;
            ack0_d  = !grant_p1;
            ack1_d  = grant_p1;
            if (grant_p1) rdata1_d = '0;
            else          rdata0_d = '0;
          end
`endif
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ack0_d  = !owner_q;
          ack1_d  = owner_q;
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata_i;
            else         rdata0_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          rd_d  = !we_q;
          wr_d  = we_q;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      p0_ack_o     <= 1'b0;
      p1_ack_o     <= 1'b0;
      p0_rdata_o   <= '0;
      p1_rdata_o   <= '0;
      busy_o       <= 1'b0;
      last_grant_o <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_o        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      mem_addr_o   <= addr_d;
      mem_wdata_o  <= wdata_d;
      mem_read_o   <= rd_d;
      mem_write_o  <= wr_d;
      p0_ack_o     <= ack0_d;
      p1_ack_o     <= ack1_d;
      p0_rdata_o   <= rdata0_d;
      p1_rdata_o   <= rdata1_d;
      busy_o       <= (state_d != S_IDLE);
      last_grant_o <= last_grant_d;
`ifdef DMEM_ALIGN_CHECK_EN
      err_o        <= err_d;
`endif
    end
  end

`ifndef DMEM_ALIGN_CHECK_EN
  logic unused_err;
  assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MEM_LAT=2) with a small behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read_o, mem_write_o, busy_o, last_grant_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int stray = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(2), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .busy_o(busy_o), .last_grant_o(last_grant_o)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err)
`endif
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign err = 1'b0;
`endif

  // Word memory; unwritten words read back as 0xA5A5_00<index>.
  logic [31:0] mem [0:63];
  logic [63:0] written;
  logic [5:0]  midx;
  assign midx      = mem_addr_o[7:2];
  assign mem_rdata = written[midx] ? mem[midx] : (32'hA5A5_0000 | 32'(midx));

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) written <= '0;
    else if (mem_write_o) begin
      mem[midx]     <= mem_wdata_o;
      written[midx] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One access from a single port, started in an IDLE cycle; returns at the following IDLE cycle.
  task automatic run_req(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int wr_cyc,
                         output int rd_cyc, output logic [31:0] rdata, output logic err_seen);
    lat = 0; wr_cyc = 0; rd_cyc = 0; rdata = '0; err_seen = 1'b0;
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_write_o) wr_cyc++;
      if (mem_read_o) rd_cyc++;
      if (p0_ack && p1_ack) overlap++;
      if (port ? p0_ack : p1_ack) stray++;
      if (port ? p1_ack : p0_ack) begin
        lat = i;
        rdata = port ? p1_rdata : p0_rdata;
        err_seen = err;
        break;
      end
    end
    p0_req = 0; p1_req = 0;
    @(negedge clk);
  endtask

  int          lat, wc, rc, n, acks;
  logic [31:0] rd;
  logic        e;
  int          order [0:5];
  logic [31:0] lg    [0:5];
  logic [31:0] rdv   [0:5];

  // Both ports request together; records the first `cnt` acks.
  task automatic contend(input int cnt, input bit hold);
    n = 0;
    for (int i = 0; i < 6; i++) begin order[i] = -1; lg[i] = 'x; rdv[i] = 'x; end
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int i = 0; i < 80 && n < cnt; i++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) overlap++;
      if (p0_ack) begin
        order[n] = 0; lg[n] = 32'(last_grant_o); rdv[n] = p0_rdata; n++;
        if (!hold) p0_req = 0;
      end else if (p1_ack) begin
        order[n] = 1; lg[n] = 32'(last_grant_o); rdv[n] = p1_rdata; n++;
        if (!hold) p1_req = 0;
      end
    end
    p0_req = 0; p1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_i = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    #3;
    chk("rst_ctrl", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    chk("rst_busy_grant", {30'd0, busy_o, last_grant_o}, 32'd0);
    chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #20 rst_i = 1;
    @(negedge clk);

    // Contention from reset: p0 first, then p1.
    contend(2, 1'b0);
    chk("cont_first", 32'(order[0]), 32'd0);
    chk("cont_lg0", lg[0], 32'd0);
    chk("cont_rd0", rdv[0], 32'hA5A5_0000);
    chk("cont_second", 32'(order[1]), 32'd1);
    chk("cont_lg1", lg[1], 32'd1);
    chk("cont_rd1", rdv[1], 32'hA5A5_0001);

    // Fairness with both requests held: 0,1,0,1,0,1.
    contend(6, 1'b1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fair_%0d", i), 32'(order[i]), 32'(i % 2));
    chk("fair_busy_idle", 32'(busy_o), 32'd0);

    // Write then read on port 0.
    run_req(0, 1, 32'd8, 32'hDEAD_BEEF, lat, wc, rc, rd, e);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_cycles", 32'(wc), 32'd2);
    chk("wr_no_read", 32'(rc), 32'd0);
    chk("wr_rdata_held", p0_rdata, 32'hA5A5_0000);
    chk("wr_busy_idle", 32'(busy_o), 32'd0);
    run_req(0, 0, 32'd8, 32'h0, lat, wc, rc, rd, e);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_cycles", 32'(rc), 32'd2);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(e), 32'd0);
    chk("rd_held_idle", p0_rdata, 32'hDEAD_BEEF);

`ifdef DMEM_ALIGN_CHECK_EN
    run_req(0, 0, 32'h6, 32'h0, lat, wc, rc, rd, e);
    chk("al_lat", 32'(lat), 32'd1);
    chk("al_no_read", 32'(rc), 32'd0);
    chk("al_err", 32'(e), 32'd1);
    chk("al_rdata", rd, 32'd0);
    chk("al_err_low", 32'(err), 32'd0);
    run_req(0, 0, 32'd8, 32'h0, lat, wc, rc, rd, e);
    chk("al_next_err", 32'(e), 32'd0);
    chk("al_next_data", rd, 32'hDEAD_BEEF);
`endif

    // Port 1 abandons its write after one ACCESS cycle.
    p1_req = 1; p1_we = 1; p1_addr = 32'd12; p1_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    p1_req = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (p1_ack) acks++;
      if (p0_ack) stray++;
    end
    chk("ab_acks", 32'(acks), 32'd1);
    chk("ab_busy", 32'(busy_o), 32'd0);
    chk("ab_mem", mem[3], 32'hCAFE_F00D);

    // Async reset mid-ACCESS (last winner was p1, so a tie afterwards proves the reset).
    p0_req = 1; p0_we = 1; p0_addr = 32'd16; p0_wdata = 32'h5555_5555;
    @(negedge clk);
    chk("ra_write_on", 32'(mem_write_o), 32'd1);
    #2 rst_i = 0;
    #1;
    chk("ra_ctrl", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    chk("ra_busy", 32'(busy_o), 32'd0);
    chk("ra_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    p0_req = 0;
    @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    contend(1, 1'b0);
    chk("ra_tie_p0", 32'(order[0]), 32'd0);

    chk("ack_overlap", 32'(overlap), 32'd0);
    chk("stray_ack", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
